uart_tx: RTL and testbench

- UART0 transmit path: a byte FIFO feeding an 8N1 serializer with an integer baud divider.
- Sits between the UART0 register decode (writes to the TX data register) and the `tx` pad.
- Produces the level interrupt that drives the UART0TX bit (trap code 17) of the interrupt CSRs.

---
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit path: circular byte FIFO feeding an 8N1 serializer.
// Bit time is CLK_FREQ/BAUD core cycles; irq is high while fully drained.
module uart_tx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          busy,
  output logic          tx,
  output logic          irq
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be >= 1");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_FREQ/BAUD must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push, pop, bit_end;

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign busy     = (state != IDLE);
  assign irq      = empty & ~busy;
  assign bit_end  = (baud_cnt == BIT_LAST);
  assign push     = wr_en & ~full;
  // Pop on leaving IDLE, or at the end of STOP to chain frames without a gap.
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // tx is updated together with the state so each level starts on the
  // same edge as the bit it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-timer model of the serial line.
module tb_uart_tx;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          full, empty, overflow, busy, tx, irq;
  logic [CW-1:0] count;

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: FIFO contents as a queue, current frame as (byte, cycles elapsed).
  logic [7:0] mq[$];
  bit         m_act = 1'b0;
  int         m_ft  = 0;
  logic [7:0] m_cur = '0;
  bit         m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_tx();
    int p;
    if (!m_act) return 1'b1;
    p = m_ft / DIV;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_cur[p-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input bit w, input logic [7:0] d, input bit r);
    bit full_pre, do_pop;
    if (r) begin
      mq.delete();
      m_act = 1'b0;
      m_ft  = 0;
      m_ovf = 1'b0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      do_pop   = (mq.size() > 0) && (!m_act || m_ft == FRAME - 1);
      m_ovf    = w && full_pre;
      if (m_act) begin
        m_ft++;
        if (m_ft == FRAME) m_act = 1'b0;
      end
      if (do_pop) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_ft  = 0;
      end
      if (w && !full_pre) mq.push_back(d);
    end
  endtask

  task automatic compare();
    chk("tx",       {31'b0, tx},       {31'b0, exp_tx()});
    chk("count",    32'(count),        mq.size());
    chk("empty",    {31'b0, empty},    {31'b0, mq.size() == 0});
    chk("full",     {31'b0, full},     {31'b0, mq.size() == DEPTH});
    chk("busy",     {31'b0, busy},     {31'b0, m_act});
    chk("irq",      {31'b0, irq},      {31'b0, (mq.size() == 0) && !m_act});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r);
    wr_en   = w;
    wr_data = d;
    rst     = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    compare();
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_act || mq.size() != 0) && guard < 12 * FRAME) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    if (m_act || mq.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int guard;
    // Reset held for three cycles.
    repeat (3) step(1'b0, 8'h00, 1'b1);
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_irq", {31'b0, irq}, 1);
    chk("rst_count", 32'(count), 0);

    // Single byte; start bit must appear two edges after the push.
    step(1'b1, 8'hA5, 1'b0);
    chk("lat_empty", {31'b0, empty}, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("lat_tx_start", {31'b0, tx}, 0);
    drain();
    chk("a5_irq", {31'b0, irq}, 1);

    // Back-to-back frames.
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    drain();

    // Fill while busy, then overflow; then overflow on a STOP-pop edge.
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("ovf_full", {31'b0, full}, 1);
    chk("ovf_pulse", {31'b0, overflow}, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_one_cycle", {31'b0, overflow}, 0);
    guard = 0;
    while (!(m_act && m_ft == FRAME - 1) && guard < 2 * FRAME) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    if (guard >= 2 * FRAME) chk("stop_wait_timeout", 0, 1);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_on_pop", {31'b0, overflow}, 1);
    drain();

    // Pointer wrap across several refills.
    for (int i = 1; i <= 11; i++) begin
      guard = 0;
      while (mq.size() == DEPTH && guard < 2 * FRAME) begin
        step(1'b0, 8'h00, 1'b0);
        guard++;
      end
      step(1'b1, 8'(i), 1'b0);
    end
    drain();

    // Reset during data bit 3 with two bytes queued.
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    guard = 0;
    while (!(m_act && m_cur == 8'h3C && m_ft / DIV == 4) && guard < 2 * FRAME) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    if (guard >= 2 * FRAME) chk("bit3_wait_timeout", 0, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("midrst_tx", {31'b0, tx}, 1);
    chk("midrst_count", 32'(count), 0);
    repeat (3 * FRAME) step(1'b0, 8'h00, 1'b0);

    // Random traffic with varying push density and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      int dens = $urandom_range(2, 25);
      for (int c = 0; c < 500; c++) begin
        step($urandom_range(0, 99) < dens, 8'($urandom), $urandom_range(0, 999) == 0);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
